// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring division, one
// quotient bit per clock, with sign fix-up and single-cycle special cases.
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic           rem_sel_q, rem_sel_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           a_neg, b_neg, ovf, ge;
  logic [W:0]     rem_sh;
  logic [W-1:0]   trial;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rem_sel_q <= rem_sel_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rem_sel_d = rem_sel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;

    a_neg  = ~op[0] & dividend[W-1];
    b_neg  = ~op[0] & divisor[W-1];
    ovf    = ~op[0] && (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
    rem_sh = {rem_q, quo_q[W-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    // When ge holds the true difference is below dvs_q, so W bits suffice
    trial  = rem_sh[W-1:0] - dvs_q;

    case (state_q)
      IDLE: begin
        if (done_q) busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d    = 1'b1;
          rem_sel_d = op[1];
          cnt_d     = '0;
          dvs_d     = b_neg ? -divisor : divisor;
          if (divisor == '0) begin
            // Final values are loaded directly; sign fix disabled
            quo_d   = '1;
            rem_d   = dividend;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIN;
          end else if (ovf) begin
            quo_d   = {1'b1, {(W-1){1'b0}}};
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIN;
          end else begin
            quo_d   = a_neg ? -dividend : dividend;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (ge) begin
          rem_d = trial;
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = FIN;
      end
      FIN: begin
        if (rem_sel_q) result_d = rneg_q ? -rem_q : rem_q;
        else           result_d = qneg_q ? -quo_q : quo_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Issue one op, scramble inputs afterwards, wait for done; returns in the done cycle
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 1; bcnt = 0; seen = 0;
    while (lat <= 40) begin
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
    end else begin
      chk({name, "_result"}, result, exp);
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_busycycles"}, 32'(bcnt), 32'(exp_lat));
    end
  endtask

  initial begin
    logic [31:0] a, b, prev, r;
    logic [1:0]  o;
    int          ndone;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{"divu_100_7",   2'd1, 32'd100,        32'd7,          32'd14,         34});
    vecs.push_back('{"rem_m7_2",     2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34});
    vecs.push_back('{"div_m7_2",     2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
    vecs.push_back('{"divu_by0",     2'd1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  2});
    vecs.push_back('{"remu_by0",     2'd3, 32'h1234,       32'd0,          32'h1234,       2});
    vecs.push_back('{"div_5_by0",    2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  2});
    vecs.push_back('{"rem_by0_neg",  2'd2, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  2});
    vecs.push_back('{"div_ovf",      2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2});
    vecs.push_back('{"rem_ovf",      2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2});
    vecs.push_back('{"divu_min_m1",  2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34});
    vecs.push_back('{"div_7_m2",     2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34});
    vecs.push_back('{"rem_7_m2",     2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          34});
    vecs.push_back('{"divu_max_1",   2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34});

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Back-to-back: issue in the cycle after done; prior result must hold meanwhile
    run_op("b2b_first", 2'd1, 32'd100, 32'd7, 32'd14, 34);
    @(negedge clk);
    start = 1'b1; op = 2'd3; dividend = 32'hFFFF_FFFF; divisor = 32'd16;
    @(negedge clk);
    start = 1'b0;
    prev = result;
    chk("b2b_accepted_busy", 32'(busy), 32'd1);
    chk("b2b_prev_hold", prev, 32'd14);
    ndone = 1;
    while (!done && ndone < 40) begin
      if (result !== 32'd14) begin
        chk("b2b_hold_cycle", result, 32'd14);
        break;
      end
      @(negedge clk);
      ndone++;
    end
    chk("b2b_latency", 32'(ndone), 32'd34);
    chk("b2b_result", result, 32'd15);

    // Start during the done cycle must be ignored
    start = 1'b1; op = 2'd1; dividend = 32'd50; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_cycle_start_done", 32'(done), 32'd0);
    chk("done_cycle_start_result", result, 32'd15);

    // Re-assert start at cycle 10 of an op: ignored, single done pulse
    start = 1'b1; op = 2'd1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; r = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        start = 1'b1; op = 2'd2; dividend = 32'd1000; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        r = result;
        chk("ignore_latency", 32'(c), 32'd34);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_result", r, 32'd14);

    // Asynchronous reset mid-division
    start = 1'b1; op = 2'd1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("prereset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("postreset_activity", 32'(ndone), 32'd0);

    // Randomized operations against the reference model
    for (int k = 0; k < 60; k++) begin
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      run_op("random", o, a, b, model(o, a, b), model_lat(o, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider: DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage and performs the inverse of multiply/shift-left: restoring division, one quotient bit per clock.
- Controller stalls the pipeline while busy=1 and writes result back on the done pulse.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend  input  DATA_WIDTH  rs1 value
divisor  input  DATA_WIDTH  rs2 value
busy  output  1  high from the cycle after start acceptance until done cycle inclusive
done  output  1  one-cycle pulse, result valid
result  output  DATA_WIDTH  quotient or remainder per op; holds until next done

Behaviour:
- Reset (rst_n=0, asynchronous, any state including mid-division): state=IDLE, busy=0, done=0, result=0, counter/internal registers=0.
- States: IDLE, CALC, FIN.
  - IDLE: on start=1 at edge E0, capture op, operand sign flags and |operands| (unsigned ops use raw values). Go to CALC with count=0, remainder reg=0, quotient reg=dividend magnitude.
  - CALC: each edge performs one restoring step.
    - Shift {rem,quo} left 1; trial = rem - divisor magnitude (DATA_WIDTH+1 bits).
    - If trial non-negative: rem=trial, quo LSB=1; else quo LSB=0.
    - count increments. After step DATA_WIDTH (edge E32), go to FIN.
  - FIN: at next edge (E33), register the signed-fixed result, done=1 for exactly that cycle, state returns to IDLE.
- Latency: done high in cycle following E33, i.e. 34 cycles after start is sampled; busy high for cycles after E0 through done cycle.
- Sign fix (DIV/REM only):
  - Quotient negated if dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops use no fix.
- Special cases, detected at E0, skip CALC (IDLE→FIN directly, done after E1):
  - Divisor=0: quotient = all ones (DIV and DIVU); remainder = dividend unmodified.
  - Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- start while busy=1 or in done cycle: ignored, no queueing. start in IDLE the cycle after done is accepted normally.
- Inputs are only sampled at E0; changes during CALC have no effect.
- done and busy are registered outputs; no combinational path from inputs to outputs.

Test Plan:
1. DIVU dividend=100, divisor=7, start 1 cycle -> done exactly 34 cycles later; result=14; busy high 34 cycles.
2. REM dividend=0xFFFFFFF9 (-7), divisor=2 -> result=0xFFFFFFFF (-1). DIV, same operands -> result=0xFFFFFFFD (-3).
3. Divide by zero:
   - DIVU 0x1234/0 -> done 2 cycles after start, result=0xFFFFFFFF.
   - REMU 0x1234/0 -> result=0x1234.
   - DIV 5/0 -> result=0xFFFFFFFF.
4. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 in 2 cycles. REM, same operands -> result=0.
5. Handshake and reset:
   - Assert start again at cycle 10 of a DIVU 100/7 -> ignored, single done, result=14.
   - Pulse rst_n low at cycle 15 of a new op -> busy=0, done=0, result=0 immediately; no done pulse follows.
6. Back-to-back: start in the cycle after done with REMU 0xFFFFFFFF/16 -> result=15 after 34 cycles. Previous result holds until then.
